// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and small helpers for the sync generator.
// Used by vga_line_counter and vga_sync_gen.
package vga_timing_pkg;

    localparam int CNT_W       = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Half-open window test: lo <= val < hi
    function automatic logic in_window(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_line_counter.sv
// Vertical line counter advanced on the rising edge of the upstream end-of-line flag.
// wrap is high in the cycle whose clock edge takes line_cnt from V_TOTAL-1 back to 0.
module vga_line_counter
    import vga_timing_pkg::*;
#(
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             vflag,
    output logic [CNT_W-1:0] line_cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_TOTAL - 1);

    logic vflag_d_r;
    logic advance_s;

    // Rising-edge detect on vflag and wrap decode at the last line
    always_comb begin
        advance_s = vflag & ~vflag_d_r;
        wrap      = advance_s && (line_cnt == LINE_LAST);
    end

    // Line counter state; reset overrides any advance in the same cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vflag_d_r <= 1'b0;
            line_cnt  <= {CNT_W{1'b0}};
        end else begin
            vflag_d_r <= vflag;
            if (wrap) begin
                line_cnt <= {CNT_W{1'b0}};
            end else if (advance_s) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end else begin
                line_cnt <= line_cnt;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/visible-area generator driven by an upstream horizontal pixel counter.
// Optional frame_tick output is enabled by defining VGA_FRAME_TICK_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] cntHorizontal,
    input  logic             vflag,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic             frame_tick
`endif
);

    localparam logic [CNT_W-1:0] H_VIS_L   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_TOTAL_L = CNT_W'(H_TOTAL_DEF);
    localparam logic [CNT_W-1:0] V_VIS_L   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [CNT_W-1:0] line_cnt_s;
    logic             h_active_s;
    logic             hsync_s;
    logic             vsync_s;
    logic             video_on_s;
    logic [CNT_W-1:0] pixel_x_s;
    logic [CNT_W-1:0] pixel_y_s;

`ifdef VGA_FRAME_TICK_EN
    logic wrap_s;
`else
    logic wrap_unused_s;
`endif

    vga_line_counter #(
        .V_TOTAL (V_TOTAL)
    ) u_line_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .vflag    (vflag),
        .line_cnt (line_cnt_s),
`ifdef VGA_FRAME_TICK_EN
        .wrap     (wrap_s)
`else
        .wrap     (wrap_unused_s)
`endif
    );

    // Next-output decode; columns past the line length are pure blanking
    always_comb begin
        h_active_s = (cntHorizontal < H_TOTAL_L);
        hsync_s    = ~(h_active_s && in_window(cntHorizontal, HS_START, HS_END));
        vsync_s    = ~in_window(line_cnt_s, VS_START, VS_END);
        video_on_s = h_active_s && (cntHorizontal < H_VIS_L) && (line_cnt_s < V_VIS_L);
        if (video_on_s) begin
            pixel_x_s = cntHorizontal;
            pixel_y_s = line_cnt_s;
        end else begin
            pixel_x_s = {CNT_W{1'b0}};
            pixel_y_s = {CNT_W{1'b0}};
        end
    end

    // Output registers, one cycle behind the sampled column and line
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            pixel_x  <= {CNT_W{1'b0}};
            pixel_y  <= {CNT_W{1'b0}};
        end else begin
            hsync    <= hsync_s;
            vsync    <= vsync_s;
            video_on <= video_on_s;
            pixel_x  <= pixel_x_s;
            pixel_y  <= pixel_y_s;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Frame tick pulses once, right after the line counter wraps to 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap_s;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: constant vector table, directed corner
// sequences and random stimulus against an arithmetic frame-position model.
module tb_vga_sync_gen;

    logic       Clk;
    logic       Reset;
    logic [9:0] cntHorizontal;
    logic       vflag;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: current line and previous vflag
    int m_line = 0;
    int m_prev = 0;
    int m_tick = 0;

    vga_sync_gen dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .cntHorizontal (cntHorizontal),
        .vflag         (vflag),
        .hsync         (hsync),
        .vsync         (vsync),
        .video_on      (video_on),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick    (frame_tick)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] h;
        logic       hs;
        logic       vo;
        logic [9:0] px;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, predict from the pre-edge model, advance model, compare
    task automatic cyc(input logic [9:0] h, input logic v, input logic r);
        logic       e_hs, e_vs, e_vo;
        logic [9:0] e_px, e_py;
        int         hi;
        hi = int'(h);
        cntHorizontal = h;
        vflag = v;
        Reset = r;
        if (r) begin
            e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0; e_px = 10'd0; e_py = 10'd0;
        end else begin
            e_hs = !(hi >= 656 && hi < 752);
            e_vs = !(m_line >= 490 && m_line < 492);
            e_vo = (hi < 640) && (m_line < 480);
            e_px = e_vo ? h : 10'd0;
            e_py = e_vo ? 10'(m_line) : 10'd0;
        end
        @(posedge Clk);
        m_tick = 0;
        if (r) begin
            m_line = 0;
            m_prev = 0;
        end else begin
            if (v && m_prev == 0) begin
                m_line = m_line + 1;
                if (m_line == 525) begin
                    m_line = 0;
                    m_tick = 1;
                end
            end
            m_prev = int'(v);
        end
        #1;
        chk("outputs {hs,vs,vo,px,py}", {9'd0, hsync, vsync, video_on, pixel_x, pixel_y},
            {9'd0, e_hs, e_vs, e_vo, e_px, e_py});
`ifdef VGA_FRAME_TICK_EN
        chk("frame_tick", {31'd0, frame_tick}, 32'(m_tick));
`endif
    endtask

    // Single-cycle vflag pulses until the model reaches the target line
    task automatic pulse_to(input int target);
        for (int n = 0; n < 600 && m_line != target; n++) begin
            cyc(10'd800, 1'b1, 1'b0);
            cyc(10'd800, 1'b0, 1'b0);
        end
    endtask

    vec_t vt[12];

    initial begin
        int hs_low;
        int vo_high;
        int ticks;
        logic       rv;
        logic [9:0] rh;

        vt[0]  = '{10'd0,    1'b1, 1'b1, 10'd0};
        vt[1]  = '{10'd1,    1'b1, 1'b1, 10'd1};
        vt[2]  = '{10'd639,  1'b1, 1'b1, 10'd639};
        vt[3]  = '{10'd640,  1'b1, 1'b0, 10'd0};
        vt[4]  = '{10'd655,  1'b1, 1'b0, 10'd0};
        vt[5]  = '{10'd656,  1'b0, 1'b0, 10'd0};
        vt[6]  = '{10'd751,  1'b0, 1'b0, 10'd0};
        vt[7]  = '{10'd752,  1'b1, 1'b0, 10'd0};
        vt[8]  = '{10'd799,  1'b1, 1'b0, 10'd0};
        vt[9]  = '{10'd800,  1'b1, 1'b0, 10'd0};
        vt[10] = '{10'd900,  1'b1, 1'b0, 10'd0};
        vt[11] = '{10'd1023, 1'b1, 1'b0, 10'd0};

        cntHorizontal = 10'd800;
        vflag = 1'b0;
        Reset = 1'b1;

        // Reset for 3 cycles, then idle
        for (int i = 0; i < 3; i++) cyc(10'd800, 1'b0, 1'b1);
        cyc(10'd800, 1'b0, 1'b0);
        chk("idle after reset", {27'd0, hsync, vsync, video_on, pixel_x == 10'd0, pixel_y == 10'd0},
            {27'd0, 5'b11011});

        // Constant vector table at line 0
        foreach (vt[i]) begin
            cyc(vt[i].h, 1'b0, 1'b0);
            chk("table hsync", {31'd0, hsync}, {31'd0, vt[i].hs});
            chk("table video_on", {31'd0, video_on}, {31'd0, vt[i].vo});
            chk("table pixel_x", {22'd0, pixel_x}, {22'd0, vt[i].px});
        end

        // Full line sweep at line 0
        hs_low = 0;
        vo_high = 0;
        for (int h = 0; h < 800; h++) begin
            cyc(10'(h), 1'b0, 1'b0);
            if (!hsync) hs_low++;
            if (video_on) vo_high++;
        end
        chk("sweep hsync low count", 32'(hs_low), 32'd96);
        chk("sweep video_on count", 32'(vo_high), 32'd640);

        // vflag held 5 cycles advances exactly one line
        for (int i = 0; i < 5; i++) cyc(10'd800, 1'b1, 1'b0);
        cyc(10'd800, 1'b0, 1'b0);
        cyc(10'd5, 1'b0, 1'b0);
        chk("held vflag line", {22'd0, pixel_y}, 32'd1);

        // Line 10 with an out-of-range column
        pulse_to(10);
        cyc(10'd900, 1'b0, 1'b0);
        chk("col 900 blank", {29'd0, hsync, video_on, pixel_x == 10'd0}, {29'd0, 3'b101});
        cyc(10'd10, 1'b0, 1'b0);
        chk("line 10 pixel_y", {22'd0, pixel_y}, 32'd10);

        // Vertical sync window boundaries
        pulse_to(489);
        cyc(10'd800, 1'b0, 1'b0);
        chk("vsync line 489", {31'd0, vsync}, 32'd1);
        pulse_to(490);
        cyc(10'd800, 1'b0, 1'b0);
        chk("vsync line 490", {31'd0, vsync}, 32'd0);
        pulse_to(491);
        cyc(10'd800, 1'b0, 1'b0);
        chk("vsync line 491", {31'd0, vsync}, 32'd0);
        pulse_to(492);
        cyc(10'd800, 1'b0, 1'b0);
        chk("vsync line 492", {31'd0, vsync}, 32'd1);

        // Frame wrap back to line 0
        pulse_to(524);
        ticks = 0;
        cyc(10'd800, 1'b1, 1'b0);
`ifdef VGA_FRAME_TICK_EN
        if (frame_tick) ticks++;
`else
        ticks++;
`endif
        cyc(10'd800, 1'b0, 1'b0);
`ifdef VGA_FRAME_TICK_EN
        if (frame_tick) ticks++;
`endif
        chk("frame tick pulses", 32'(ticks), 32'd1);
        cyc(10'd3, 1'b0, 1'b0);
        chk("wrapped line 0", {21'd0, video_on, pixel_y}, {21'd0, 1'b1, 10'd0});

        // Reset mid-frame at line 300, then first edge gives line 1
        pulse_to(300);
        cyc(10'd20, 1'b1, 1'b1);
        chk("mid reset outputs", {27'd0, hsync, vsync, video_on, pixel_x == 10'd0, pixel_y == 10'd0},
            {27'd0, 5'b11011});
        cyc(10'd800, 1'b1, 1'b0);
        cyc(10'd800, 1'b0, 1'b0);
        cyc(10'd7, 1'b0, 1'b0);
        chk("line after reset", {22'd0, pixel_y}, 32'd1);

        // Random stimulus against the model
        rv = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(3, 0) == 0) rh = 10'($urandom_range(1023, 0));
            else rh = 10'($urandom_range(799, 0));
            if ($urandom_range(2, 0) == 0) rv = ~rv;
            cyc(rh, rv, ($urandom_range(499, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-005 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-006 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-007 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-008 SHALL have port Clk, input, 1 bit, system clock; reset Reset, synchronous, active-high.
REQ-009 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port cntHorizontal, input, 10 bits, current pixel column, 0..799, from upstream horizontal counter.
REQ-011 SHALL have port vflag, input, 1 bit, end-of-line indication from upstream, one or more cycles high once per line.
REQ-012 SHALL have port hsync, output, 1 bit, horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1 bit, vertical sync, active-low.
REQ-014 SHALL have port video_on, output, 1 bit, high inside the visible area.
REQ-015 SHALL have port pixel_x, output, 10 bits, visible column, else 0.
REQ-016 SHALL have port pixel_y, output, 10 bits, visible line, else 0.

Function
REQ-017 SHALL hold a 10-bit line counter line_cnt, range 0..V_TOTAL-1.
REQ-018 SHALL register vflag into vflag_d each cycle; line advance event = vflag & ~vflag_d (rising edge only; a vflag held high for N cycles gives exactly one advance).
REQ-019 On advance, line_cnt SHALL increment by 1; at V_TOTAL-1 it SHALL wrap to 0.
REQ-020 All outputs SHALL be registered; outputs after edge k SHALL be computed from cntHorizontal sampled at edge k and line_cnt value before edge k (one-cycle latency).
REQ-021 hsync SHALL be 0 when H_VISIBLE+H_FP <= cntHorizontal < H_VISIBLE+H_FP+H_SYNC (656..751), else 1.
REQ-022 vsync SHALL be 0 when V_VISIBLE+V_FP <= line_cnt < V_VISIBLE+V_FP+V_SYNC (490..491), else 1.
REQ-023 video_on SHALL be 1 iff cntHorizontal < H_VISIBLE and line_cnt < V_VISIBLE.
REQ-024 pixel_x/pixel_y SHALL equal cntHorizontal/line_cnt when video_on is computed 1, else 0.
REQ-025 cntHorizontal >= 800 SHALL be treated as blanking: hsync 1, video_on 0, no line_cnt effect.
REQ-026 Advance event and wrap in the same cycle SHALL produce line_cnt 0 only, no skipped or double count.

Reset
REQ-027 Reset high at an edge SHALL set line_cnt 0, vflag_d 0, hsync 1, vsync 1, video_on 0, pixel_x 0, pixel_y 0, frame_tick 0, overriding any advance that cycle.
REQ-028 Reset mid-frame SHALL restart at line 0; the first vflag rising edge after release SHALL advance to line 1.

Configuration
REQ-029 Macro VGA_FRAME_TICK_EN defined: SHALL add output frame_tick, 1 bit, registered one-cycle pulse in the cycle after line_cnt wraps V_TOTAL-1 -> 0.
REQ-030 Macro VGA_FRAME_TICK_EN undefined: SHALL omit the frame_tick port and its logic; all other behaviour identical.

Structure
REQ-031 Timing defaults (640/16/96/48, 480/10/2/33, H_TOTAL 800, V_TOTAL 525) SHALL live in shared package vga_timing_pkg.
REQ-032 Line counter plus vflag edge detect SHALL be sub-module vga_line_counter (Clk, Reset, vflag, line_cnt, wrap).

Verification
REQ-033 Reset held 3 cycles, then release with idle inputs -> hsync 1, vsync 1, video_on 0, pixel_x 0, pixel_y 0.
REQ-034 Sweep cntHorizontal 0..799, line 0 -> hsync 0 exactly for inputs 656..751; video_on 1 for 0..639; pixel_x equals input one cycle later.
REQ-035 Drive 490 single-cycle vflag pulses -> vsync 0 during lines 490..491 only; 525 pulses -> line_cnt back to 0, frame_tick one pulse (macro on).
REQ-036 vflag held high 5 cycles -> line_cnt advances by exactly 1.
REQ-037 Reset asserted at line 300 -> line_cnt 0, outputs at reset values next cycle; next vflag edge -> line 1.
REQ-038 cntHorizontal 900 at line 10 -> hsync 1, video_on 0, pixel_x 0.
